// File: rtl/bloco_operativo.sv
// Datapath for a small polynomial evaluator. It holds three 16-bit working
// registers (RX, RH, RS) fed by one shared combinational ALU that either
// adds or multiplies. It also keeps a sticky overflow flag and captures RS
// into RESULT on each rising edge of the controller's 'finished' signal.
module bloco_operativo (
    input  logic        clk,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  X_IN,
    input  logic [7:0]  COEF_A,
    input  logic [7:0]  COEF_B,
    input  logic [7:0]  COEF_C,
    input  logic        LX,
    input  logic        LH,
    input  logic        LS,
    input  logic        H,
    input  logic [1:0]  M0,
    input  logic [1:0]  M1,
    input  logic [1:0]  M2,
    input  logic        finished,
    output logic [15:0] RESULT,
    output logic        RESULT_VALID,
    output logic        OVF
);

    logic [15:0] rx_q, rx_d;
    logic [15:0] rh_q, rh_d;
    logic [15:0] rs_q, rs_d;
    logic [15:0] result_q, result_d;
    logic        fin_q, fin_d;      // finished delayed by one cycle
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;

    logic [15:0] x_ext;
    logic [15:0] k_val;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] prod;
    logic [16:0] sum;
    logic [15:0] alu_res;
    logic        alu_ovf;
    logic        fin_rise;
    logic        any_load;

    assign x_ext = {8'd0, X_IN};

    // Operand muxes and ALU; sources are always the pre-edge register values
    always_comb begin
        k_val = 16'd0;
        case (M0)
            2'b00: k_val = 16'd0;
            2'b01: k_val = {8'd0, COEF_A};
            2'b10: k_val = {8'd0, COEF_B};
            2'b11: k_val = {8'd0, COEF_C};
            default: k_val = 16'd0;
        endcase

        op_a = rx_q;
        case (M1)
            2'b00: op_a = rx_q;
            2'b01: op_a = x_ext;
            2'b10: op_a = rh_q;
            2'b11: op_a = rs_q;
            default: op_a = rx_q;
        endcase

        op_b = x_ext;
        case (M2)
            2'b00: op_b = x_ext;
            2'b01: op_b = rh_q;
            2'b10: op_b = rs_q;
            2'b11: op_b = k_val;
            default: op_b = x_ext;
        endcase

        prod = op_a * op_b;
        sum  = {1'b0, op_a} + {1'b0, op_b};

        if (H) begin
            alu_res = prod[15:0];
            alu_ovf = |prod[31:16];
        end else begin
            alu_res = sum[15:0];
            alu_ovf = sum[16];
        end
    end

    // Next-state: register loads, sticky overflow, result capture on finished rise
    always_comb begin
        rx_d     = LX ? alu_res : rx_q;
        rh_d     = LH ? alu_res : rh_q;
        rs_d     = LS ? alu_res : rs_q;
        fin_d    = finished;
        any_load = LX | LH | LS;
        fin_rise = finished & ~fin_q;

        // Setting the flag takes priority over a START clear on the same edge
        ovf_d = ovf_q;
        if (any_load && alu_ovf)
            ovf_d = 1'b1;
        else if (START)
            ovf_d = 1'b0;

        // START suppresses the pulse and leaves RESULT untouched
        valid_d  = fin_rise & ~START;
        result_d = (fin_rise && !START) ? rs_q : result_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_q     <= 16'd0;
            rh_q     <= 16'd0;
            rs_q     <= 16'd0;
            result_q <= 16'd0;
            fin_q    <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rx_q     <= rx_d;
            rh_q     <= rh_d;
            rs_q     <= rs_d;
            result_q <= result_d;
            fin_q    <= fin_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign OVF          = ovf_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Bench for bloco_operativo: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a model.
module tb_bloco_operativo;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  X_IN = 8'd0;
    logic [7:0]  COEF_A = 8'd0;
    logic [7:0]  COEF_B = 8'd0;
    logic [7:0]  COEF_C = 8'd0;
    logic        LX = 1'b0;
    logic        LH = 1'b0;
    logic        LS = 1'b0;
    logic        H = 1'b0;
    logic [1:0]  M0 = 2'd0;
    logic [1:0]  M1 = 2'd0;
    logic [1:0]  M2 = 2'd0;
    logic        finished = 1'b0;
    logic [15:0] RESULT;
    logic        RESULT_VALID;
    logic        OVF;

    int checks = 0;
    int failures = 0;

    bloco_operativo dut (
        .clk(clk), .RST(RST), .START(START), .X_IN(X_IN),
        .COEF_A(COEF_A), .COEF_B(COEF_B), .COEF_C(COEF_C),
        .LX(LX), .LH(LH), .LS(LS), .H(H),
        .M0(M0), .M1(M1), .M2(M2), .finished(finished),
        .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_rx = 0, m_rh = 0, m_rs = 0, m_result = 0;
    bit          m_fin = 0, m_rv = 0, m_ovf = 0;

    function automatic int unsigned pick_a();
        int unsigned opts[4];
        opts = '{m_rx, int'(X_IN), m_rh, m_rs};
        return opts[M1];
    endfunction

    function automatic int unsigned pick_b();
        int unsigned ks[4];
        int unsigned opts[4];
        ks   = '{0, int'(COEF_A), int'(COEF_B), int'(COEF_C)};
        opts = '{int'(X_IN), m_rh, m_rs, ks[M0]};
        return opts[M2];
    endfunction

    // Full-precision arithmetic; value is wrapped to 16 bits, ov marks the excess
    function automatic int unsigned alu_val();
        longint unsigned r;
        r = H ? longint'(pick_a()) * longint'(pick_b()) : longint'(pick_a()) + longint'(pick_b());
        return int'(r % 65536);
    endfunction

    function automatic bit alu_ov();
        longint unsigned r;
        r = H ? longint'(pick_a()) * longint'(pick_b()) : longint'(pick_a()) + longint'(pick_b());
        return r > 65535;
    endfunction

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            m_rx <= 0; m_rh <= 0; m_rs <= 0; m_result <= 0;
            m_fin <= 0; m_rv <= 0; m_ovf <= 0;
        end else begin
            if (LX) m_rx <= alu_val();
            if (LH) m_rh <= alu_val();
            if (LS) m_rs <= alu_val();
            if ((LX || LH || LS) && alu_ov()) m_ovf <= 1;
            else if (START) m_ovf <= 0;
            m_fin <= finished;
            m_rv  <= finished && !m_fin && !START;
            if (finished && !m_fin && !START) m_result <= m_rs;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        chk("cmp_result", 32'(RESULT), m_result);
        chk("cmp_valid", 32'(RESULT_VALID), 32'(m_rv));
        chk("cmp_ovf", 32'(OVF), 32'(m_ovf));
        chk("cmp_rx", 32'(dut.rx_q), m_rx);
        chk("cmp_rh", 32'(dut.rh_q), m_rh);
        chk("cmp_rs", 32'(dut.rs_q), m_rs);
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input bit lx, input bit lh, input bit ls, input bit h,
                      input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                      input logic [7:0] x);
        @(negedge clk); #1;
        LX = lx; LH = lh; LS = ls; H = h; M0 = m0; M1 = m1; M2 = m2; X_IN = x;
        START = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit fin, input bit st);
        @(negedge clk); #1;
        LX = 0; LH = 0; LS = 0; finished = fin; START = st;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_result", 32'(RESULT), 32'd0);
        chk("rst_valid", 32'(RESULT_VALID), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        @(negedge clk); #1; RST = 0;

        // Square: 3*3 into RX
        op(1, 0, 0, 1, 2'd0, 2'd1, 2'd0, 8'd3);
        chk("sq_rx", 32'(dut.rx_q), 32'd9);
        chk("sq_ovf", 32'(OVF), 32'd0);

        // Full flow: RH = RX*COEF_A, RS = RH + RS, then finished rise
        COEF_A = 8'd2;
        op(0, 1, 0, 1, 2'd1, 2'd0, 2'd3, 8'd0);
        chk("flow_rh", 32'(dut.rh_q), 32'd18);
        op(0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 8'd0);
        chk("flow_rs", 32'(dut.rs_q), 32'd18);
        idle(1, 0);
        chk("flow_result", 32'(RESULT), 32'd18);
        chk("flow_valid1", 32'(RESULT_VALID), 32'd1);
        idle(1, 0);
        chk("flow_valid2", 32'(RESULT_VALID), 32'd0);
        idle(1, 0);
        chk("flow_valid3", 32'(RESULT_VALID), 32'd0);
        chk("hold_rx", 32'(dut.rx_q), 32'd9);
        chk("hold_rh", 32'(dut.rh_q), 32'd18);
        chk("hold_result", 32'(RESULT), 32'd18);
        idle(0, 0);

        // Multiply overflow
        op(1, 0, 0, 1, 2'd0, 2'd1, 2'd0, 8'd255);
        chk("mov_rx0", 32'(dut.rx_q), 32'hFE01);
        op(1, 0, 0, 1, 2'd0, 2'd0, 2'd0, 8'd255);
        chk("mov_rx1", 32'(dut.rx_q), 32'h02FF);
        chk("mov_ovf1", 32'(OVF), 32'd1);
        idle(0, 0);
        chk("mov_sticky", 32'(OVF), 32'd1);
        idle(0, 1);
        chk("mov_clear", 32'(OVF), 32'd0);
        chk("start_keeps_result", 32'(RESULT), 32'd18);

        // Add wrap: build RS=0xFFFF and RH=1, then RS+RH
        op(0, 1, 0, 1, 2'd0, 2'd1, 2'd0, 8'd255);   // RH = FE01
        op(0, 1, 0, 0, 2'd0, 2'd1, 2'd1, 8'd255);   // RH = FF00
        op(0, 1, 0, 0, 2'd0, 2'd1, 2'd1, 8'd255);   // RH = FFFF
        op(0, 0, 1, 0, 2'd0, 2'd1, 2'd1, 8'd0);     // RS = FFFF
        op(0, 1, 0, 1, 2'd0, 2'd1, 2'd0, 8'd1);     // RH = 1
        chk("wrap_pre_ovf", 32'(OVF), 32'd0);
        chk("wrap_pre_rs", 32'(dut.rs_q), 32'hFFFF);
        op(0, 0, 1, 0, 2'd0, 2'd3, 2'd1, 8'd0);
        chk("wrap_rs", 32'(dut.rs_q), 32'h0000);
        chk("wrap_ovf", 32'(OVF), 32'd1);

        // Reset mid-flow with RS=18
        op(0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 8'd18);
        chk("mid_rs", 32'(dut.rs_q), 32'd18);
        @(negedge clk); #1;
        LS = 0; #1 RST = 1; #1;
        chk("mid_result", 32'(RESULT), 32'd0);
        chk("mid_valid", 32'(RESULT_VALID), 32'd0);
        chk("mid_ovf", 32'(OVF), 32'd0);
        chk("mid_rs0", 32'(dut.rs_q), 32'd0);
        RST = 0;
        for (int i = 0; i < 3; i++) begin
            idle(0, 0);
            chk("mid_nopulse", 32'(RESULT_VALID), 32'd0);
        end

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            X_IN = 8'($urandom); COEF_A = 8'($urandom);
            COEF_B = 8'($urandom); COEF_C = 8'($urandom);
            LX = ($urandom_range(0, 2) == 0); LH = ($urandom_range(0, 2) == 0);
            LS = ($urandom_range(0, 2) == 0); H = 1'($urandom);
            M0 = 2'($urandom); M1 = 2'($urandom); M2 = 2'($urandom);
            START = ($urandom_range(0, 7) == 0);
            finished = ($urandom_range(0, 3) == 0) ? ~finished : finished;
            if ($urandom_range(0, 59) == 0) begin
                #1 RST = 1; #2 RST = 0;
            end
        end
        idle(0, 0);
        idle(0, 0);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
